// File: rtl/fpnew_pkg.sv
// fpnew_pkg: shared FPU types, here the result arbitration mode
package fpnew_pkg;
  typedef enum logic {RR_ARB, IN_ORDER} arb_mode_e;
endpackage

// File: rtl/fpnew_idx_fifo.sv
// fpnew_idx_fifo: small FIFO of channel indices recording issue order
module fpnew_idx_fifo #(
  parameter int Depth = 8,
  parameter int IdxW  = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [IdxW-1:0] data_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [IdxW-1:0] head_o
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  logic [IdxW-1:0] mem_q [Depth];
  logic [PtrW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic [CntW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == CntW'(Depth);
  assign empty_o = cnt_q == '0;
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign wr_d    = (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + PtrW'(1);
  assign rd_d    = (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + PtrW'(1);
  // pointer and occupancy bookkeeping; flush empties the queue
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_d;
      if (do_pop) rd_q <= rd_d;
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end
  // storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/fpnew_result_arbiter.sv
// fpnew_result_arbiter: merges per-channel FPU results into one registered output
module fpnew_result_arbiter import fpnew_pkg::*; #(
  parameter int        NumIn      = 4,
  parameter int        DataWidth  = 64,
  parameter arb_mode_e Mode       = RR_ARB,
  parameter int        OrderDepth = 8,
  localparam int       IdxW       = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           issue_valid_i,
  input  logic [IdxW-1:0]                issue_idx_i,
  output logic                           issue_ready_o,
  input  logic [NumIn-1:0]               in_valid_i,
  output logic [NumIn-1:0]               in_ready_o,
  input  logic [NumIn-1:0][DataWidth-1:0] in_data_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [DataWidth-1:0]           out_data_o,
  output logic [IdxW-1:0]                out_idx_o,
  output logic                           busy_o
);
  logic                 out_valid_q;
  logic [DataWidth-1:0] out_data_q;
  logic [IdxW-1:0]      out_idx_q, ptr_q, ptr_d, gnt_idx;
  logic                 gnt_found, load, xfer;
  logic                 fifo_full, fifo_empty;
  logic [IdxW-1:0]      fifo_head;
  if (Mode == IN_ORDER) begin : g_order
    logic idx_ok;
    assign idx_ok        = {1'b0, issue_idx_i} < (IdxW + 1)'(NumIn);
    assign issue_ready_o = ~fifo_full;
    fpnew_idx_fifo #(.Depth(OrderDepth), .IdxW(IdxW)) u_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .flush_i(flush_i),
      .push_i (issue_valid_i & idx_ok),
      .data_i (issue_idx_i),
      .pop_i  (xfer),
      .full_o (fifo_full),
      .empty_o(fifo_empty),
      .head_o (fifo_head)
    );
  end else begin : g_rr
    logic unused_issue;
    assign unused_issue  = ^{issue_valid_i, issue_idx_i};
    assign issue_ready_o = 1'b1;
    assign fifo_full     = 1'b0;
    assign fifo_empty    = 1'b1;
    assign fifo_head     = '0;
  end
  assign load = ~out_valid_q | out_ready_i;
  // pick the channel to grant: FIFO head in order mode, else first valid from ptr
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    if (Mode == IN_ORDER) begin
      gnt_found = ~fifo_empty & in_valid_i[fifo_head];
      gnt_idx   = fifo_head;
    end else begin
      for (int i = NumIn - 1; i >= 0; i--) begin
        if (in_valid_i[IdxW'((int'(ptr_q) + i) % NumIn)]) begin
          gnt_found = 1'b1;
          gnt_idx   = IdxW'((int'(ptr_q) + i) % NumIn);
        end
      end
    end
  end
  assign in_ready_o = (load & ~flush_i & gnt_found) ? {{(NumIn-1){1'b0}}, 1'b1} << gnt_idx : '0;
  assign xfer       = |in_ready_o;
  assign ptr_d      = (gnt_idx == IdxW'(NumIn - 1)) ? '0 : gnt_idx + IdxW'(1);
  // output register and round-robin pointer; payload only moves on a transfer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      ptr_q       <= '0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      if (load) out_valid_q <= xfer;
      if (xfer) begin
        out_data_q <= in_data_i[gnt_idx];
        out_idx_q  <= gnt_idx;
        ptr_q      <= ptr_d;
      end
    end
  end
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign busy_o      = out_valid_q | (|in_valid_i) | ~fifo_empty;
endmodule

// File: tb/tb_fpnew_result_arbiter.sv
// tb_fpnew_result_arbiter: directed checks of round-robin and in-order arbitration
module tb_fpnew_result_arbiter;
  import fpnew_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_bad = 0;
  logic             rr_flush, rr_issue_valid, rr_issue_ready, rr_out_valid, rr_out_ready, rr_busy;
  logic [1:0]       rr_issue_idx, rr_out_idx;
  logic [3:0]       rr_in_valid, rr_in_ready;
  logic [3:0][15:0] rr_in_data;
  logic [15:0]      rr_out_data;
  logic             io_flush, io_issue_valid, io_issue_ready, io_out_valid, io_out_ready, io_busy;
  logic [1:0]       io_issue_idx, io_out_idx;
  logic [2:0]       io_in_valid, io_in_ready;
  logic [2:0][15:0] io_in_data;
  logic [15:0]      io_out_data;
  int               drain [4] = '{2, 0, 2, 1};

  fpnew_result_arbiter #(.NumIn(4), .DataWidth(16), .Mode(RR_ARB), .OrderDepth(8)) u_rr (
    .clk_i(clk), .rst_i(rst), .flush_i(rr_flush),
    .issue_valid_i(rr_issue_valid), .issue_idx_i(rr_issue_idx), .issue_ready_o(rr_issue_ready),
    .in_valid_i(rr_in_valid), .in_ready_o(rr_in_ready), .in_data_i(rr_in_data),
    .out_valid_o(rr_out_valid), .out_ready_i(rr_out_ready), .out_data_o(rr_out_data),
    .out_idx_o(rr_out_idx), .busy_o(rr_busy)
  );
  fpnew_result_arbiter #(.NumIn(3), .DataWidth(16), .Mode(IN_ORDER), .OrderDepth(4)) u_io (
    .clk_i(clk), .rst_i(rst), .flush_i(io_flush),
    .issue_valid_i(io_issue_valid), .issue_idx_i(io_issue_idx), .issue_ready_o(io_issue_ready),
    .in_valid_i(io_in_valid), .in_ready_o(io_in_ready), .in_data_i(io_in_data),
    .out_valid_o(io_out_valid), .out_ready_i(io_out_ready), .out_data_o(io_out_data),
    .out_idx_o(io_out_idx), .busy_o(io_busy)
  );

  function automatic logic [15:0] dat(input int c);
    return 16'hA000 + 16'(c) * 16'h0111;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic io_issue(input int c);
    io_issue_valid = 1'b1;
    io_issue_idx   = 2'(c);
    step();
    io_issue_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rr_flush = 0; rr_issue_valid = 0; rr_issue_idx = 0; rr_in_valid = 0; rr_out_ready = 1;
    io_flush = 0; io_issue_valid = 0; io_issue_idx = 0; io_in_valid = 0; io_out_ready = 1;
    for (int c = 0; c < 4; c++) rr_in_data[c] = dat(c);
    for (int c = 0; c < 3; c++) io_in_data[c] = dat(c);
    #12;
    chk("rst_valid", 32'(rr_out_valid), 0);
    chk("rst_data", 32'(rr_out_data), 0);
    chk("rst_idx", 32'(rr_out_idx), 0);
    chk("rst_rr_issue_ready", 32'(rr_issue_ready), 1);
    chk("rst_io_issue_ready", 32'(io_issue_ready), 1);
    chk("rst_io_busy", 32'(io_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    rr_in_valid = 4'hF;
    #1;
    chk("rr_first_grant", 32'(rr_in_ready), 32'h1);
    foreach (drain[k]) begin end
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_seq_valid", 32'(rr_out_valid), 1);
      chk("rr_seq_idx", 32'(rr_out_idx), 32'(k % 4));
      chk("rr_seq_data", 32'(rr_out_data), 32'(dat(k % 4)));
    end
    rr_in_valid = 4'b0100;
    step();
    chk("rr_hold_load_idx", 32'(rr_out_idx), 2);
    rr_out_ready = 1'b0;
    rr_in_data[2] = 16'h5555;
    #1;
    chk("rr_hold_ready0", 32'(rr_in_ready), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rr_hold_valid", 32'(rr_out_valid), 1);
      chk("rr_hold_data", 32'(rr_out_data), 32'(dat(2)));
      chk("rr_hold_ready", 32'(rr_in_ready), 0);
    end
    rr_out_ready = 1'b1;
    #1;
    chk("rr_release_grant", 32'(rr_in_ready), 32'b0100);
    step();
    chk("rr_release_data", 32'(rr_out_data), 32'h5555);
    rr_in_data[2] = dat(2);
    rr_in_valid = 4'b0011;
    #1;
    chk("rr_wrap_grant", 32'(rr_in_ready), 32'b0001);
    rr_in_valid = 4'b0010;
    #1;
    chk("rr_skip_grant", 32'(rr_in_ready), 32'b0010);
    step();
    chk("rr_pre_reset_idx", 32'(rr_out_idx), 1);
    rr_in_valid = 4'b1001;
    #2 rst = 1'b1;
    #1;
    chk("rr_async_valid", 32'(rr_out_valid), 0);
    chk("rr_async_data", 32'(rr_out_data), 0);
    rst = 1'b0;
    #1;
    chk("rr_post_reset_grant", 32'(rr_in_ready), 32'b0001);
    step();
    chk("rr_post_reset_idx", 32'(rr_out_idx), 0);
    chk("rr_post_reset_valid", 32'(rr_out_valid), 1);
    rr_in_valid = 4'b0000;
    step();
    chk("rr_idle_valid", 32'(rr_out_valid), 0);
    chk("rr_idle_busy", 32'(rr_busy), 0);

    io_issue(2); io_issue(0); io_issue(1);
    chk("io_busy_pending", 32'(io_busy), 1);
    io_in_valid = 3'b001;
    #1;
    chk("io_block_ch0", 32'(io_in_ready), 0);
    step();
    chk("io_block_out", 32'(io_out_valid), 0);
    io_in_valid = 3'b011;
    #1;
    chk("io_block_ch01", 32'(io_in_ready), 0);
    io_in_valid = 3'b111;
    #1;
    chk("io_grant_ch2", 32'(io_in_ready), 32'b100);
    step();
    chk("io_out_2", 32'(io_out_idx), 2);
    chk("io_out_2_data", 32'(io_out_data), 32'(dat(2)));
    io_in_valid = 3'b011;
    #1;
    chk("io_grant_ch0", 32'(io_in_ready), 32'b001);
    step();
    chk("io_out_0", 32'(io_out_idx), 0);
    io_in_valid = 3'b010;
    #1;
    chk("io_grant_ch1", 32'(io_in_ready), 32'b010);
    step();
    chk("io_out_1", 32'(io_out_idx), 1);
    io_in_valid = 3'b000;
    step();
    chk("io_drained_valid", 32'(io_out_valid), 0);
    chk("io_drained_busy", 32'(io_busy), 0);

    io_issue(3);
    #1;
    chk("io_drop_busy", 32'(io_busy), 0);
    chk("io_drop_ready", 32'(io_issue_ready), 1);
    io_issue(0); io_issue(1); io_issue(2);
    chk("io_three_ready", 32'(io_issue_ready), 1);
    io_issue(0);
    chk("io_full", 32'(io_issue_ready), 0);
    io_issue_valid = 1'b1;
    io_issue_idx = 2'd1;
    io_in_valid = 3'b111;
    #1;
    chk("io_full_pop_grant", 32'(io_in_ready), 32'b001);
    step();
    chk("io_full_pop_idx", 32'(io_out_idx), 0);
    chk("io_full_push_refused", 32'(io_issue_ready), 1);
    io_issue_idx = 2'd2;
    #1;
    chk("io_pushpop_grant", 32'(io_in_ready), 32'b010);
    step();
    chk("io_pushpop_idx", 32'(io_out_idx), 1);
    chk("io_pushpop_ready", 32'(io_issue_ready), 1);
    io_in_valid = 3'b000;
    io_issue_idx = 2'd1;
    step();
    io_issue_valid = 1'b0;
    chk("io_refill_full", 32'(io_issue_ready), 0);
    io_in_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("io_drain_grant", 32'(io_in_ready), 32'(1 << drain[k]));
      step();
      chk("io_drain_idx", 32'(io_out_idx), 32'(drain[k]));
      chk("io_drain_data", 32'(io_out_data), 32'(dat(drain[k])));
    end
    io_in_valid = 3'b000;
    step();
    chk("io_drain_done", 32'(io_out_valid), 0);
    for (int k = 0; k < 6; k++) begin
      io_issue((k + 1) % 3);
      io_in_valid = 3'(1 << ((k + 1) % 3));
      #1;
      chk("io_wrap_grant", 32'(io_in_ready), 32'(1 << ((k + 1) % 3)));
      step();
      chk("io_wrap_idx", 32'(io_out_idx), 32'((k + 1) % 3));
      io_in_valid = 3'b000;
    end

    io_out_ready = 1'b0;
    io_issue(1);
    io_in_valid = 3'b010;
    step();
    io_in_valid = 3'b000;
    chk("io_flush_pre_valid", 32'(io_out_valid), 1);
    io_issue(0); io_issue(2); io_issue(1);
    io_out_ready = 1'b1;
    io_flush = 1'b1;
    io_issue_valid = 1'b1;
    io_issue_idx = 2'd2;
    io_in_valid = 3'b001;
    #1;
    chk("io_flush_no_grant", 32'(io_in_ready), 0);
    step();
    io_flush = 1'b0;
    io_issue_valid = 1'b0;
    io_in_valid = 3'b000;
    #1;
    chk("io_flush_valid", 32'(io_out_valid), 0);
    chk("io_flush_ready", 32'(io_issue_ready), 1);
    chk("io_flush_busy", 32'(io_busy), 0);
    io_in_valid = 3'b111;
    #1;
    chk("io_flush_empty", 32'(io_in_ready), 0);
    io_in_valid = 3'b000;
    step();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
